// File: rtl/sdp_fifo_ctrl.sv
// Synchronous FIFO controller around a simple-dual-port BRAM with a 2-entry output buffer.
// Optional combinational read-data bypass to the pop port: define SDP_FIFO_BYPASS_EN.
module sdp_fifo_ctrl #(
  parameter int ABITS     = 10,
  parameter int DBITS     = 36,
  parameter int NBYTES    = 4,
  parameter int BYTEWIDTH = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DBITS-1:0]   s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DBITS-1:0]   m_data,
  output logic [ABITS+1:0]   count,
  output logic [ABITS-1:0]   ram_wa,
  output logic [DBITS-1:0]   ram_wd,
  output logic               ram_we,
  output logic [NBYTES-1:0]  ram_be,
  output logic [ABITS-1:0]   ram_ra,
  output logic               ram_re,
  input  logic [DBITS-1:0]   ram_rd
);

  if (DBITS != NBYTES * BYTEWIDTH) begin : g_bad_cfg
    $error("sdp_fifo_ctrl: DBITS must equal NBYTES*BYTEWIDTH");
  end

  localparam logic [ABITS:0]   DEPTH   = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS-1:0] PTR_ONE = {{(ABITS-1){1'b0}}, 1'b1};
  localparam logic [ABITS:0]   CNT_ONE = {{ABITS{1'b0}}, 1'b1};

  // Handshakes: a word moves on a port when valid && ready at posedge clk.
  logic [ABITS-1:0] wptr, rptr;
  logic [ABITS:0]   mem_cnt;
  logic             inflight;
  logic [1:0]       buf_cnt;
  logic [DBITS-1:0] buf0, buf1;

  logic       push, pop, bypass_pop, buf_pop, buf_wr;
  logic [1:0] cnt_mid;
  logic [2:0] occ;

  assign s_ready = rst_n && (mem_cnt != DEPTH);
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

`ifdef SDP_FIFO_BYPASS_EN
  // Empty buffer with a read landing: present ram_rd directly to the pop port.
  assign m_valid    = (buf_cnt != 2'd0) || inflight;
  assign m_data     = (buf_cnt == 2'd0) ? ram_rd : buf0;
  assign bypass_pop = (buf_cnt == 2'd0) && inflight && pop;
`else
  assign m_valid    = (buf_cnt != 2'd0);
  assign m_data     = buf0;
  assign bypass_pop = 1'b0;
`endif

  // A read is only issued if its data is guaranteed a buffer slot when it lands.
  assign occ     = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign ram_re  = (mem_cnt != '0) && (occ < 3'd2);
  assign buf_pop = pop && !bypass_pop;
  assign buf_wr  = inflight && !bypass_pop;
  assign cnt_mid = buf_cnt - {1'b0, buf_pop};

  assign ram_wa = wptr;
  assign ram_wd = s_data;
  assign ram_we = push;
  assign ram_be = {NBYTES{1'b1}};
  assign ram_ra = rptr;
  assign count  = {1'b0, mem_cnt} + {{(ABITS+1){1'b0}}, inflight} + {{ABITS{1'b0}}, buf_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
    end else begin
      if (push)   wptr <= wptr + PTR_ONE;
      if (ram_re) rptr <= rptr + PTR_ONE;
      case ({push, ram_re})
        2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
        2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
        default: mem_cnt <= mem_cnt;
      endcase
      inflight <= ram_re;
      buf_cnt  <= cnt_mid + {1'b0, buf_wr};
    end
  end

  // Data path: shift on pop first, then land the returning read in the first free slot.
  always_ff @(posedge clk) begin
    if (buf_pop) buf0 <= buf1;
    if (buf_wr) begin
      if (cnt_mid == 2'd0) buf0 <= ram_rd;
      else                 buf1 <= ram_rd;
    end
  end

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Self-checking bench for sdp_fifo_ctrl: behavioural RAM, queue-based reference and scoreboard.
module tb_sdp_fifo_ctrl;

  localparam int ABITS  = 10;
  localparam int DBITS  = 36;
  localparam int NBYTES = 4;
  localparam int BW     = 9;
  localparam int DEPTH  = 1 << ABITS;
`ifdef SDP_FIFO_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid, s_ready, m_valid, m_ready;
  logic [DBITS-1:0]  s_data, m_data;
  logic [ABITS+1:0]  count;
  logic [ABITS-1:0]  ram_wa, ram_ra;
  logic [DBITS-1:0]  ram_wd, ram_rd;
  logic              ram_we, ram_re;
  logic [NBYTES-1:0] ram_be;

  sdp_fifo_ctrl #(.ABITS(ABITS), .DBITS(DBITS), .NBYTES(NBYTES), .BYTEWIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count),
    .ram_wa(ram_wa), .ram_wd(ram_wd), .ram_we(ram_we), .ram_be(ram_be),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_rd(ram_rd)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference state ----------------
  logic [DBITS-1:0] exp_q[$];
  logic [DBITS-1:0] mem [DEPTH];
  logic [DBITS-1:0] rd_pend;
  logic             re_pend = 1'b0;
  int checks = 0, errors = 0;
  int wr_n = 0, rd_n = 0, mem_occ = 0, infl = 0;
  int cyc = 0, pops = 0, first_pop = 0, last_pop = 0;
  logic rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural RAM: samples request at negedge, presents read data at the next posedge.
  always @(posedge clk) if (re_pend) ram_rd <= rd_pend;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("ram_we", 64'(ram_we), 64'(s_valid && s_ready));
      if (ram_we) begin
        chk("ram_wa", 64'(ram_wa), 64'(wr_n % DEPTH));
        chk("ram_wd", 64'(ram_wd), 64'(s_data));
        chk("ram_be", 64'(ram_be), 64'hf);
      end
      if (ram_re) begin
        chk("re_nonempty", 64'(mem_occ != 0), 64'd1);
        chk("ram_ra", 64'(ram_ra), 64'(rd_n % DEPTH));
      end
      chk("no_collision", 64'(ram_we && ram_re && (ram_wa == ram_ra)), 64'd0);
      chk("buf_bound", 64'((exp_q.size() - mem_occ - infl) <= 2), 64'd1);
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_empty act=%0h exp=none", m_data);
        end else begin
          logic [DBITS-1:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL pop_data act=%0h exp=%0h", m_data, e);
          end
        end
        pops++;
        if (pops == 1) first_pop = cyc;
        last_pop = cyc;
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
      wr_n    += int'(ram_we);
      rd_n    += int'(ram_re);
      mem_occ += int'(ram_we) - int'(ram_re);
      infl     = int'(ram_re);
    end
    re_pend = ram_re;
    if (ram_re) rd_pend = mem[ram_ra];
    if (ram_we) mem[ram_wa] = ram_wd;
  end

  always @(posedge clk) if (rand_rdy) begin
    #1 m_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- drivers ----------------
  task automatic push_word(input logic [DBITS-1:0] d);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("push_timeout", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int t = 0;
    m_ready = 1'b1;
    @(negedge clk);
    while (count != 0 && t < max) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 64'(count), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    wr_n = 0; rd_n = 0; mem_occ = 0; infl = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_count",   64'(count),   64'd0);
    chk("rst_ram_we",  64'(ram_we),  64'd0);
    chk("rst_ram_re",  64'(ram_re),  64'd0);
    rst_n = 1'b1;

    // single word latency
    @(posedge clk); #1;
    m_ready = 1'b1; s_valid = 1'b1; s_data = 36'h000000001;
    @(posedge clk); #1 s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) chk("lat_edge1_m_valid", 64'(m_valid), 64'(BYP));
    @(posedge clk);
    @(negedge clk) chk("lat_edge2_m_valid", 64'(m_valid), 64'(!BYP));
    repeat (3) @(negedge clk);
    chk("lat_count_zero", 64'(count), 64'd0);

    // fill to full capacity with the pop port stalled, then drain
    @(posedge clk); #1 m_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) push_word(DBITS'(i));
    repeat (2) @(negedge clk);
    chk("full_count", 64'(count), 64'(DEPTH + 2));
    chk("full_s_ready", 64'(s_ready), 64'd0);
    chk("full_m_valid", 64'(m_valid), 64'd1);
    drain(3 * DEPTH);

    // sustained streaming: one pop per cycle after fill
    pops = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 4096; i++) push_word(DBITS'(i + 36'h100000000));
    drain(64);
    chk("stream_pops", 64'(pops), 64'd4096);
    chk("stream_span", 64'(last_pop - first_pop + 1), 64'd4096);

    // random back-pressure with continuous push
    rand_rdy = 1'b1;
    for (int i = 0; i < 2000; i++) push_word(DBITS'({$urandom, $urandom}));
    @(posedge clk);
    rand_rdy = 1'b0;
    #2;
    drain(3 * DEPTH);

    // reset while reads are in flight and the buffer holds data
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(DBITS'(36'hA00 + i));
    m_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_count",   64'(count),   64'd0);
    chk("midrst_ram_re",  64'(ram_re),  64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    clear_model();
    m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pops = 0;
    push_word(36'h0_1234_5678);
    push_word(36'h9_8765_4321);
    drain(32);
    chk("post_rst_pops", 64'(pops), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
